predecode_timing: RTL and testbench
===================================

// Module: predecode_timing
// PURPOSE
//  Opcode front end of the 6502C core; sits upstream of the ALU/register datapath.
//  Captures the opcode from the external data bus into the instruction register (IR).
//  Runs the T-state cycle counter and predecodes one-byte and two-cycle opcodes.
//  Arbitrates RES/NMI/IRQ and forces BRK (8'h00) into IR at the instruction boundary.
// PARAMETERS
//  T_MAX     7      last legal T-state; counter forced back to T1 past this
//  BRK_OP    8'h00  opcode injected into IR when an interrupt is taken
// PORTS
//  phi2        in   1  clock; all state updates on posedge phi2
//  RES_n       in   1  asynchronous, active-low reset
//  RDY         in   1  1 = advance; 0 = hold all state (wait-state)
//  extDataBus  in   8  external data pins; opcode sampled here in T1
//  T_END       in   1  random-control: current cycle is last of instruction
//  NMI_n       in   1  NMI pin, falling-edge sensitive
//  IRQ_n       in   1  IRQ pin, level sensitive, active low
//  I_flag      in   1  status-register I bit; 1 masks IRQ
//  IR          out  8  instruction register
//  tstate      out  3  current T-state, 1..T_MAX (0 never driven)
//  SYNC        out  1  1 while tstate==1 (opcode fetch cycle)
//  ONEBYTE     out  1  predecode of IR: no operand byte
//  TWOCYCLE    out  1  predecode of IR: instruction completes in T2
//  intForce    out  1  1 from the BRK-injecting T1 edge until next T1 edge (PC-increment suppress)
//  intSrc      out  2  00 none/BRK, 01 IRQ, 10 NMI, 11 RES; valid while intForce=1
//  tTimeout    out  1  one-cycle pulse: counter left T_MAX without T_END
// BEHAVIOUR
//  Reset (RES_n=0, async): IR=8'h00, tstate=1, intForce=0, intSrc=00, tTimeout=0,
//   nmiPend=0, nmiPrev=1, resPend=1. resPend stays 1 while RES_n low.
//  NMI edge detect every posedge phi2 regardless of RDY: nmiPrev<=NMI_n;
//   nmiPrev=1 & NMI_n=0 sets nmiPend. Set wins over same-edge clear.
//  IRQ is not latched: irqReq = ~IRQ_n & ~I_flag, sampled at the T1 edge.
//  RDY=0: IR, tstate, intForce, intSrc, resPend, nmiPend-clear all hold; tTimeout=0.
//  Posedge phi2 with RDY=1, priority order:
//   tstate==1: tstate<=2; if resPend|nmiPend|irqReq: IR<=BRK_OP, intForce<=1,
//     intSrc<= RES(11) > NMI(10) > IRQ(01), clear only the taken pending bit;
//     else IR<=extDataBus, intForce<=0, intSrc<=00.
//   tstate==2 & TWOCYCLE & ~intForce: tstate<=1 (T_END ignored).
//   T_END=1: tstate<=1.
//   tstate==T_MAX: tstate<=1, tTimeout<=1 for one cycle.
//   else tstate<=tstate+1.
//  Predecode (combinational on IR, 8-bit):
//   ONEBYTE = IR[3:0]==4'h8 | IR[3:0]==4'hA.
//   imm = IR[4:0]==5'b01001 | (IR[7] & (IR[4:0]==5'b00000 | IR[4:0]==5'b00010)).
//   TWOCYCLE = (ONEBYTE & ~(~IR[7] & ~IR[4] & IR[3:0]==4'h8)) | imm.
//    (push/pull 08/28/48/68 are one-byte but not two-cycle.)
//  Forced BRK always runs full sequence to T_END; predecode of 8'h00 gives 0/0.
//  Latency: opcode on extDataBus at T1 edge -> IR and predecode valid next cycle.
//  RES_n asserted mid-instruction: immediate async return to reset values.
// TESTING
//  Reset release, RDY=1, T_END pulsed at T6 -> first T1 edge IR=00, intSrc=11,
//   tstate 1,2..6,1; resPend cleared.
//  extDataBus=8'hA9 (LDA #) at T1 -> IR=A9, TWOCYCLE=1, tstate 1,2,1 without T_END.
//  extDataBus=8'h48 (PHA) -> ONEBYTE=1, TWOCYCLE=0; tstate 1,2,3,1 with T_END at T3.
//  NMI_n 1->0 during T3 with IRQ_n=0, I_flag=0 -> next T1: IR=00, intSrc=10;
//   following T1: intSrc=01 (IRQ still low); I_flag=1 -> opcode fetched normally.
//  RDY=0 for 3 cycles at T2 -> tstate, IR frozen; NMI edge during stall still latched.
//  No T_END for 7 cycles -> tstate 1..7 then 1, tTimeout high exactly one cycle.

Source files
------------

// File: rtl/predecode_timing_if.sv
// Opcode front-end bus: external pins and control inputs in, IR/T-state/predecode out.
`timescale 1ns/1ps
interface predecode_timing_if;
    logic       RDY;
    logic [7:0] extDataBus;
    logic       T_END;
    logic       NMI_n;
    logic       IRQ_n;
    logic       I_flag;
    logic [7:0] IR;
    logic [2:0] tstate;
    logic       SYNC;
    logic       ONEBYTE;
    logic       TWOCYCLE;
    logic       intForce;
    logic [1:0] intSrc;
    logic       tTimeout;

    modport master (
        output RDY, extDataBus, T_END, NMI_n, IRQ_n, I_flag,
        input  IR, tstate, SYNC, ONEBYTE, TWOCYCLE, intForce, intSrc, tTimeout
    );

    modport slave (
        input  RDY, extDataBus, T_END, NMI_n, IRQ_n, I_flag,
        output IR, tstate, SYNC, ONEBYTE, TWOCYCLE, intForce, intSrc, tTimeout
    );
endinterface

// File: rtl/predecode_timing.sv
// 6502C opcode front end: IR capture, T-state counter, predecode, RES/NMI/IRQ -> BRK injection.
// Latency: opcode sampled at the T1 edge; IR and predecode valid the following cycle.
// Backpressure: RDY=0 freezes IR, T-state and interrupt bookkeeping; NMI edges are still caught.
`timescale 1ns/1ps
module predecode_timing #(
    parameter int         T_MAX  = 7,
    parameter logic [7:0] BRK_OP = 8'h00
) (
    input  logic              phi2,
    input  logic              RES_n,
    predecode_timing_if.slave bus
);
    localparam logic [2:0] TMAX3 = 3'(T_MAX);

    logic [7:0] ir;
    logic [2:0] tstate;
    logic       int_force;
    logic [1:0] int_src;
    logic       t_timeout;
    logic       nmi_pend;
    logic       nmi_prev;
    logic       res_pend;

    logic       t1;
    logic       irq_req;
    logic       int_req;
    logic       nmi_edge;
    logic       take_nmi;
    logic       one_byte;
    logic       imm;
    logic       two_cycle;

    assign t1       = (tstate == 3'd1);
    assign irq_req  = ~bus.IRQ_n & ~bus.I_flag;
    assign int_req  = res_pend | nmi_pend | irq_req;
    assign nmi_edge = nmi_prev & ~bus.NMI_n;
    // RES outranks NMI, so a pending NMI survives a reset-sourced BRK.
    assign take_nmi = bus.RDY & t1 & ~res_pend & nmi_pend;

    // Push/pull (08/28/48/68) are one-byte but need stack cycles.
    assign one_byte  = (ir[3:0] == 4'h8) | (ir[3:0] == 4'hA);
    assign imm       = (ir[4:0] == 5'b01001) |
                       (ir[7] & ((ir[4:0] == 5'b00000) | (ir[4:0] == 5'b00010)));
    assign two_cycle = (one_byte & ~(~ir[7] & ~ir[4] & (ir[3:0] == 4'h8))) | imm;

    always_ff @(posedge phi2 or negedge RES_n) begin
        if (!RES_n) begin
            ir        <= 8'h00;
            tstate    <= 3'd1;
            int_force <= 1'b0;
            int_src   <= 2'b00;
            t_timeout <= 1'b0;
            nmi_pend  <= 1'b0;
            nmi_prev  <= 1'b1;
            res_pend  <= 1'b1;
        end else begin
            nmi_prev  <= bus.NMI_n;
            t_timeout <= 1'b0;

            if (nmi_edge)
                nmi_pend <= 1'b1;
            else if (take_nmi)
                nmi_pend <= 1'b0;

            if (bus.RDY) begin
                if (t1) begin
                    tstate <= 3'd2;
                    if (int_req) begin
                        ir        <= BRK_OP;
                        int_force <= 1'b1;
                        if (res_pend) begin
                            int_src  <= 2'b11;
                            res_pend <= 1'b0;
                        end else if (nmi_pend) begin
                            int_src <= 2'b10;
                        end else begin
                            int_src <= 2'b01;
                        end
                    end else begin
                        ir        <= bus.extDataBus;
                        int_force <= 1'b0;
                        int_src   <= 2'b00;
                    end
                end else if ((tstate == 3'd2) && two_cycle && !int_force) begin
                    tstate <= 3'd1;
                end else if (bus.T_END) begin
                    tstate <= 3'd1;
                end else if (tstate >= TMAX3) begin
                    tstate    <= 3'd1;
                    t_timeout <= 1'b1;
                end else begin
                    tstate <= tstate + 3'd1;
                end
            end
        end
    end

    assign bus.IR       = ir;
    assign bus.tstate   = tstate;
    assign bus.SYNC     = t1;
    assign bus.ONEBYTE  = one_byte;
    assign bus.TWOCYCLE = two_cycle;
    assign bus.intForce = int_force;
    assign bus.intSrc   = int_src;
    assign bus.tTimeout = t_timeout;
endmodule

// File: tb/tb_predecode_timing.sv
// Directed bench for predecode_timing: reset, opcode fetch/predecode, interrupts, stalls, timeout.
`timescale 1ns/1ps
module tb_predecode_timing;
    logic phi2;
    logic RES_n;
    int   errors;
    int   checks;

    predecode_timing_if bus ();

    predecode_timing dut (
        .phi2  (phi2),
        .RES_n (RES_n),
        .bus   (bus)
    );

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are then sampled 1ns after the rising edge.
    task automatic cyc();
        @(posedge phi2);
        #1;
    endtask

    task automatic end_instr();
        bus.T_END = 1'b1;
        cyc();
        bus.T_END = 1'b0;
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        RES_n          = 1'b0;
        bus.RDY        = 1'b1;
        bus.extDataBus = 8'h00;
        bus.T_END      = 1'b0;
        bus.NMI_n      = 1'b1;
        bus.IRQ_n      = 1'b1;
        bus.I_flag     = 1'b1;

        cyc();
        cyc();
        chk("rst_ir", bus.IR, 8'h00);
        chk("rst_tstate", {5'd0, bus.tstate}, 8'd1);
        chk("rst_sync", {7'd0, bus.SYNC}, 8'd1);
        chk("rst_intforce", {7'd0, bus.intForce}, 8'd0);
        chk("rst_intsrc", {6'd0, bus.intSrc}, 8'd0);
        chk("rst_timeout", {7'd0, bus.tTimeout}, 8'd0);

        // Reset-sourced BRK on first T1
        RES_n = 1'b1;
        bus.extDataBus = 8'hA9;
        cyc();
        chk("res_ir", bus.IR, 8'h00);
        chk("res_intsrc", {6'd0, bus.intSrc}, 8'b11);
        chk("res_intforce", {7'd0, bus.intForce}, 8'd1);
        chk("res_tstate", {5'd0, bus.tstate}, 8'd2);
        chk("brk_predecode", {6'd0, bus.ONEBYTE, bus.TWOCYCLE}, 8'b00);
        for (int t = 3; t <= 6; t++) begin
            cyc();
            chk("res_seq", {5'd0, bus.tstate}, 8'(t));
        end
        end_instr();
        chk("res_back_t1", {5'd0, bus.tstate}, 8'd1);
        chk("res_force_hold", {7'd0, bus.intForce}, 8'd1);

        // LDA # : two-cycle, returns to T1 without T_END
        cyc();
        chk("lda_ir", bus.IR, 8'hA9);
        chk("lda_sync", {7'd0, bus.SYNC}, 8'd0);
        chk("lda_intforce", {7'd0, bus.intForce}, 8'd0);
        chk("lda_intsrc", {6'd0, bus.intSrc}, 8'd0);
        chk("lda_predecode", {6'd0, bus.ONEBYTE, bus.TWOCYCLE}, 8'b01);
        cyc();
        chk("lda_t1", {5'd0, bus.tstate}, 8'd1);

        // PHA : one-byte, not two-cycle
        bus.extDataBus = 8'h48;
        cyc();
        chk("pha_ir", bus.IR, 8'h48);
        chk("pha_predecode", {6'd0, bus.ONEBYTE, bus.TWOCYCLE}, 8'b10);
        cyc();
        chk("pha_t3", {5'd0, bus.tstate}, 8'd3);
        end_instr();
        chk("pha_t1", {5'd0, bus.tstate}, 8'd1);

        // LDA abs, NMI edge during T3 with IRQ also asserted
        bus.extDataBus = 8'hAD;
        cyc();
        chk("ldaabs_predecode", {6'd0, bus.ONEBYTE, bus.TWOCYCLE}, 8'b00);
        cyc();
        chk("ldaabs_t3", {5'd0, bus.tstate}, 8'd3);
        bus.NMI_n  = 1'b0;
        bus.IRQ_n  = 1'b0;
        bus.I_flag = 1'b0;
        cyc();
        end_instr();
        cyc();
        chk("nmi_ir", bus.IR, 8'h00);
        chk("nmi_intsrc", {6'd0, bus.intSrc}, 8'b10);
        chk("nmi_intforce", {7'd0, bus.intForce}, 8'd1);
        cyc();
        cyc();
        end_instr();
        cyc();
        chk("irq_intsrc", {6'd0, bus.intSrc}, 8'b01);
        chk("irq_ir", bus.IR, 8'h00);
        cyc();
        end_instr();
        bus.I_flag     = 1'b1;
        bus.extDataBus = 8'hEA;
        cyc();
        chk("nop_ir", bus.IR, 8'hEA);
        chk("nop_intsrc", {6'd0, bus.intSrc}, 8'd0);
        chk("nop_predecode", {6'd0, bus.ONEBYTE, bus.TWOCYCLE}, 8'b11);
        cyc();
        chk("nop_t1", {5'd0, bus.tstate}, 8'd1);
        bus.IRQ_n = 1'b1;
        bus.NMI_n = 1'b1;

        // RDY stall at T2; NMI edge arrives during the stall
        bus.extDataBus = 8'hAD;
        cyc();
        bus.RDY        = 1'b0;
        bus.extDataBus = 8'hFF;
        cyc();
        bus.NMI_n = 1'b0;
        cyc();
        cyc();
        chk("stall_tstate", {5'd0, bus.tstate}, 8'd2);
        chk("stall_ir", bus.IR, 8'hAD);
        chk("stall_timeout", {7'd0, bus.tTimeout}, 8'd0);
        bus.RDY = 1'b1;
        cyc();
        chk("stall_resume", {5'd0, bus.tstate}, 8'd3);
        end_instr();
        cyc();
        chk("stall_nmi_ir", bus.IR, 8'h00);
        chk("stall_nmi_src", {6'd0, bus.intSrc}, 8'b10);
        cyc();
        end_instr();
        bus.NMI_n = 1'b1;

        // No T_END: counter runs to T_MAX then times out
        bus.extDataBus = 8'hAD;
        cyc();
        for (int t = 3; t <= 7; t++) begin
            cyc();
            chk("to_seq", {5'd0, bus.tstate}, 8'(t));
            chk("to_quiet", {7'd0, bus.tTimeout}, 8'd0);
        end
        cyc();
        chk("to_t1", {5'd0, bus.tstate}, 8'd1);
        chk("to_pulse", {7'd0, bus.tTimeout}, 8'd1);
        cyc();
        chk("to_pulse_end", {7'd0, bus.tTimeout}, 8'd0);
        chk("to_next_ir", bus.IR, 8'hAD);

        // Async reset mid-instruction, then reset BRK again
        RES_n = 1'b0;
        #1;
        chk("arst_tstate", {5'd0, bus.tstate}, 8'd1);
        chk("arst_ir", bus.IR, 8'h00);
        #2;
        RES_n = 1'b1;
        cyc();
        chk("arst_res_src", {6'd0, bus.intSrc}, 8'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
